// File: rtl/reorder_commit.sv
// Reorder buffer with in-order commit: hands out tags at dispatch, accepts results
// in any order, and retires at most one head entry per cycle to the register file.
module reorder_commit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int DEPTH      = 8,
    localparam int AW = $clog2(NUM_REGS),
    localparam int TW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_rd,
    input  logic                  alloc_has_dest,
    output logic                  alloc_ready,
    output logic [TW-1:0]         alloc_tag,
    input  logic                  cmpl_valid,
    input  logic [TW-1:0]         cmpl_tag,
    input  logic [DATA_WIDTH-1:0] cmpl_data,
    input  logic                  flush,
    output logic                  w_en,
    output logic [AW-1:0]         w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [TW:0]           count,
    output logic                  empty
);
    localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_has_dest;
    logic [AW-1:0]         ent_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [TW-1:0]         head;
    logic [TW-1:0]         tail;
    logic                  alloc_fire;
    logic                  cmpl_fire;
    logic                  retire_fire;

    // Readiness looks at the current count only, so a full buffer cannot refill the slot retiring this cycle.
    assign alloc_ready = rst_n && !flush && (count < FULL);
    assign alloc_tag   = tail;
    assign empty       = (count == '0);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign cmpl_fire   = rst_n && !flush && cmpl_valid && ent_valid[cmpl_tag] && !ent_done[cmpl_tag];
    assign retire_fire = rst_n && !flush && ent_valid[head] && ent_done[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            w_en      <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            w_en      <= 1'b0;
        end else begin
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + TW'(1);
            end
            if (cmpl_fire) begin
                ent_done[cmpl_tag] <= 1'b1;
            end
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + TW'(1);
                w_addr          <= ent_rd[head];
                w_data          <= ent_data[head];
            end
            w_en <= retire_fire && ent_has_dest[head] && (ent_rd[head] != '0);
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + (TW+1)'(1);
                2'b01:   count <= count - (TW+1)'(1);
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; the valid/done bits decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_rd[tail]       <= alloc_rd;
            ent_has_dest[tail] <= alloc_has_dest;
        end
        if (cmpl_fire) begin
            ent_data[cmpl_tag] <= cmpl_data;
        end
    end
endmodule
